// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the N x M packet crossbar: select-width
// function, the per-output control field {en, sel} and its extraction helper.
package crossbar_pkg;

  localparam int MAX_SEL_W = 8;

  typedef struct packed {
    logic                 en;
    logic [MAX_SEL_W-1:0] sel;
  } ctrl_field_t;

  function automatic int sel_width(input int n_inputs);
    return (n_inputs > 1) ? $clog2(n_inputs) : 1;
  endfunction

  // raw holds one output's field right-aligned: enable at bit sel_w, select below it.
  function automatic ctrl_field_t get_field(input logic [MAX_SEL_W:0] raw, input int sel_w);
    ctrl_field_t f;
    f.en  = raw[sel_w];
    f.sel = '0;
    for (int b = 0; b < MAX_SEL_W; b++) begin
      if (b < sel_w) f.sel[b] = raw[b];
    end
    return f;
  endfunction

endpackage

// File: rtl/crossbar_out_buf.sv
// One-entry val/rdy pipe buffer: a full flag plus data register, accepting a
// new entry in the same cycle the held entry is dequeued.
module crossbar_out_buf #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enq_val,
  output logic                 enq_rdy,
  input  logic [BIT_WIDTH-1:0] enq_msg,
  output logic                 deq_val,
  input  logic                 deq_rdy,
  output logic [BIT_WIDTH-1:0] deq_msg,
  output logic                 full
);

  logic                 full_q;
  logic [BIT_WIDTH-1:0] data_q;

  assign enq_rdy = !full_q || deq_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (enq_val && enq_rdy) begin
      full_q <= 1'b1;
      data_q <= enq_msg;
    end else if (deq_rdy) begin
      full_q <= 1'b0;
    end
  end

  assign deq_val = full_q;
  assign deq_msg = data_q;
  assign full    = full_q;

endmodule

// File: rtl/crossbar_nxm.sv
// N-input x M-output packet crossbar routed by a stored control word.
// Define CROSSBAR_OUT_BUF_EN for a registered one-entry buffer on every output.
module crossbar_nxm
  import crossbar_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_INPUTS  = 2,
  parameter int N_OUTPUTS = 2,
  localparam int SEL_W    = sel_width(N_INPUTS),
  localparam int CTRL_W   = N_OUTPUTS * (SEL_W + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH*N_INPUTS-1:0]  recv_msg,
  input  logic [N_INPUTS-1:0]            recv_val,
  output logic [N_INPUTS-1:0]            recv_rdy,
  output logic [BIT_WIDTH*N_OUTPUTS-1:0] send_msg,
  output logic [N_OUTPUTS-1:0]           send_val,
  input  logic [N_OUTPUTS-1:0]           send_rdy,
  input  logic [CTRL_W-1:0]              control,
  input  logic                           control_val,
  output logic                           control_rdy
);

  // Handshakes: a transfer happens on a channel in a cycle where val && rdy.
  // An input is ready only when every enabled output selecting it can accept,
  // so a fanned-out message reaches all of its outputs in the same cycle.

  logic [CTRL_W-1:0]    ctrl_q;
  logic [MAX_SEL_W:0]   raw   [N_OUTPUTS];
  ctrl_field_t          fld   [N_OUTPUTS];
  logic [N_OUTPUTS-1:0] out_en;
  logic [N_OUTPUTS-1:0] out_rdy;
  logic [N_OUTPUTS-1:0] enq_val;
  logic [BIT_WIDTH-1:0] enq_msg [N_OUTPUTS];
  logic [N_INPUTS-1:0]  fire;
  logic                 any_sel;
  logic                 all_rdy;

  always_ff @(posedge clk) begin
    if (reset) ctrl_q <= '0;
    else if (control_val && control_rdy) ctrl_q <= control;
  end

  // Out-of-range selects fold into the disabled case.
  always_comb begin
    for (int o = 0; o < N_OUTPUTS; o++) begin
      raw[o]         = '0;
      raw[o][SEL_W:0] = ctrl_q[o*(SEL_W+1) +: SEL_W+1];
      fld[o]         = get_field(raw[o], SEL_W);
      out_en[o]      = fld[o].en && (int'(fld[o].sel) < N_INPUTS);
    end
  end

  always_comb begin
    recv_rdy = '0;
    any_sel  = 1'b0;
    all_rdy  = 1'b1;
    for (int i = 0; i < N_INPUTS; i++) begin
      any_sel = 1'b0;
      all_rdy = 1'b1;
      for (int o = 0; o < N_OUTPUTS; o++) begin
        if (out_en[o] && int'(fld[o].sel) == i) begin
          any_sel = 1'b1;
          all_rdy = all_rdy && out_rdy[o];
        end
      end
      recv_rdy[i] = any_sel && all_rdy;
    end
  end

  assign fire = recv_val & recv_rdy;

  always_comb begin
    for (int o = 0; o < N_OUTPUTS; o++) begin
      enq_val[o] = 1'b0;
      enq_msg[o] = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        if (out_en[o] && int'(fld[o].sel) == i) begin
          enq_val[o] = fire[i];
          enq_msg[o] = recv_msg[i*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

`ifdef CROSSBAR_OUT_BUF_EN
  logic [N_OUTPUTS-1:0] buf_full;

  for (genvar o = 0; o < N_OUTPUTS; o++) begin : g_buf
    crossbar_out_buf #(.BIT_WIDTH(BIT_WIDTH)) u_buf (
      .clk     (clk),
      .reset   (reset),
      .enq_val (enq_val[o]),
      .enq_rdy (out_rdy[o]),
      .enq_msg (enq_msg[o]),
      .deq_val (send_val[o]),
      .deq_rdy (send_rdy[o]),
      .deq_msg (send_msg[o*BIT_WIDTH +: BIT_WIDTH]),
      .full    (buf_full[o])
    );
  end

  // Routing may only change once no buffered message could be misattributed.
  assign control_rdy = ~|buf_full;
`else
  assign out_rdy     = send_rdy;
  assign send_val    = enq_val;
  assign control_rdy = 1'b1;

  for (genvar o = 0; o < N_OUTPUTS; o++) begin : g_pass
    assign send_msg[o*BIT_WIDTH +: BIT_WIDTH] = enq_msg[o];
  end
`endif

endmodule
